// File: rtl/sdrc_page_split.sv
// Purpose : splits one SDR-word request into sub-requests that never cross an SDRAM row.
// Latency : req_ack and the first sub-request both appear in the cycle after req_valid is sampled in IDLE.
// Backpr. : sub_* hold stable while sub_ack is low; req_valid is only sampled in IDLE.
//
// Ports:
//   clk, reset              sole rising-edge clock, synchronous active-high reset
//   cfg_colbits             column bits select 00=8 .. 11=11, static while busy
//   req_valid/req_ack       upstream request, ack is a one-cycle pulse on capture
//   req_addr/len/wr_n/...   request start (SDR words), word count (0 = no access), direction, DMA-last
//   sub_req/sub_ack         downstream sub-request valid, accepted on sub_ack
//   sub_addr/len/wr_n/...   chunk start, chunk word count, direction, last-of-request, DMA-last
module sdrc_page_split #(
    parameter int APP_AW = 30,
    parameter int APP_RW = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cfg_colbits,
    input  logic              req_valid,
    input  logic [APP_AW:0]   req_addr,
    input  logic [APP_RW-1:0] req_len,
    input  logic              req_wr_n,
    input  logic              req_dma_last,
    output logic              req_ack,
    output logic              sub_req,
    output logic [APP_AW:0]   sub_addr,
    output logic [APP_RW-1:0] sub_len,
    output logic              sub_wr_n,
    output logic              sub_last,
    output logic              sub_dma_last,
    input  logic              sub_ack
);

    localparam int AW1 = APP_AW + 1;
    // Length arithmetic width: wide enough for the 12-bit room value and for rem_len.
    localparam int LW  = (APP_RW > 12) ? APP_RW : 12;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [APP_AW:0]   r_cur_addr;
    logic [APP_RW-1:0] r_rem_len;
    logic              r_wr_n;
    logic              r_dma_last;
    logic              r_req_ack;

    logic [3:0]        w_colw;
    logic [11:0]       w_span;
    logic [11:0]       w_col;
    logic [11:0]       w_room;
    logic [LW-1:0]     w_rem_ext;
    logic [LW-1:0]     w_room_ext;
    logic [LW-1:0]     w_len_ext;
    logic [APP_RW-1:0] w_len;
    logic              w_last;
    logic              w_capture;

    // Chunk sizing: room left in the current row, clipped by the words still owed.
    always_comb begin
        w_colw     = 4'd8 + {2'b00, cfg_colbits};
        w_span     = 12'd1 << w_colw;
        w_col      = {1'b0, r_cur_addr[10:0]} & (w_span - 12'd1);
        w_room     = w_span - w_col;
        w_rem_ext  = LW'(r_rem_len);
        w_room_ext = LW'(w_room);
        w_last     = (w_rem_ext <= w_room_ext);
        w_len_ext  = w_last ? w_rem_ext : w_room_ext;
        // Never exceeds rem_len, so the truncation is lossless.
        w_len      = w_len_ext[APP_RW-1:0];
    end

    assign w_capture = (r_state == S_IDLE) && req_valid && (req_len != '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sub_ack && w_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request datapath and ack pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_addr <= '0;
            r_rem_len  <= '0;
            r_wr_n     <= 1'b0;
            r_dma_last <= 1'b0;
            r_req_ack  <= 1'b0;
        end else begin
            // A zero-length request is acknowledged but never enters ISSUE.
            r_req_ack <= (r_state == S_IDLE) && req_valid;
            if (w_capture) begin
                r_cur_addr <= req_addr;
                r_rem_len  <= req_len;
                r_wr_n     <= req_wr_n;
                r_dma_last <= req_dma_last;
            end else if ((r_state == S_ISSUE) && sub_ack) begin
                // Row carry propagates naturally; wraps modulo 2^(APP_AW+1).
                r_cur_addr <= r_cur_addr + AW1'(w_len);
                r_rem_len  <= r_rem_len - w_len;
            end
        end
    end

    // Outputs: sub-request fields are forced to zero outside ISSUE.
    always_comb begin
        req_ack      = r_req_ack;
        sub_req      = 1'b0;
        sub_addr     = '0;
        sub_len      = '0;
        sub_wr_n     = 1'b0;
        sub_last     = 1'b0;
        sub_dma_last = 1'b0;
        if (r_state == S_ISSUE) begin
            sub_req      = 1'b1;
            sub_addr     = r_cur_addr;
            sub_len      = w_len;
            sub_wr_n     = r_wr_n;
            sub_last     = w_last;
            sub_dma_last = r_dma_last && w_last;
        end
    end

endmodule

// File: tb/tb_sdrc_page_split.sv
// Purpose : directed-vector bench for sdrc_page_split with hand-computed chunk lists.
// Latency : inputs change and outputs are sampled on the falling edge.
// Backpr. : exercises sub_ack stalls, zero-length and back-to-back requests, mid-request reset.
module tb_sdrc_page_split;

    localparam int APP_AW = 30;
    localparam int APP_RW = 9;

    logic              clk;
    logic              reset;
    logic [1:0]        cfg_colbits;
    logic              req_valid;
    logic [APP_AW:0]   req_addr;
    logic [APP_RW-1:0] req_len;
    logic              req_wr_n;
    logic              req_dma_last;
    logic              req_ack;
    logic              sub_req;
    logic [APP_AW:0]   sub_addr;
    logic [APP_RW-1:0] sub_len;
    logic              sub_wr_n;
    logic              sub_last;
    logic              sub_dma_last;
    logic              sub_ack;

    int n_vec;
    int n_err;
    int words;

    sdrc_page_split #(.APP_AW(APP_AW), .APP_RW(APP_RW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_colbits  (cfg_colbits),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_wr_n     (req_wr_n),
        .req_dma_last (req_dma_last),
        .req_ack      (req_ack),
        .sub_req      (sub_req),
        .sub_addr     (sub_addr),
        .sub_len      (sub_len),
        .sub_wr_n     (sub_wr_n),
        .sub_last     (sub_last),
        .sub_dma_last (sub_dma_last),
        .sub_ack      (sub_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one full cycle, landing on the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_chunk(input string tag, input logic [31:0] a, input logic [31:0] l,
                             input logic lst, input logic dma, input logic wn);
        chk({tag, ".req"},  {31'd0, sub_req},      32'd1);
        chk({tag, ".addr"}, {1'b0, sub_addr},      a);
        chk({tag, ".len"},  {23'd0, sub_len},      l);
        chk({tag, ".last"}, {31'd0, sub_last},     {31'd0, lst});
        chk({tag, ".dma"},  {31'd0, sub_dma_last}, {31'd0, dma});
        chk({tag, ".wr_n"}, {31'd0, sub_wr_n},     {31'd0, wn});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".req"}, {31'd0, sub_req}, 32'd0);
        chk({tag, ".ack"}, {31'd0, req_ack}, 32'd0);
    endtask

    // Present a request for one edge; the ack must be visible in the following cycle.
    task automatic send(input string tag, input logic [31:0] a, input logic [8:0] l,
                        input logic wn, input logic dma);
        req_addr     = a[APP_AW:0];
        req_len      = l;
        req_wr_n     = wn;
        req_dma_last = dma;
        req_valid    = 1'b1;
        tick();
        chk({tag, ".ack"}, {31'd0, req_ack}, 32'd1);
        req_valid = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        words        = 0;
        reset        = 1'b1;
        cfg_colbits  = 2'b00;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_len      = '0;
        req_wr_n     = 1'b1;
        req_dma_last = 1'b0;
        sub_ack      = 1'b0;
        @(negedge clk);
        tick();
        chk("rst.req",  {31'd0, sub_req},  32'd0);
        chk("rst.ack",  {31'd0, req_ack},  32'd0);
        chk("rst.addr", {1'b0, sub_addr},  32'd0);
        chk("rst.len",  {23'd0, sub_len},  32'd0);
        chk("rst.last", {31'd0, sub_last}, 32'd0);
        reset = 1'b0;
        tick();

        // Single row: 8 column bits, 0x100 + 16 words.
        sub_ack = 1'b1;
        cfg_colbits = 2'b00;
        send("t1", 32'h100, 9'd16, 1'b1, 1'b0);
        chk_chunk("t1.c0", 32'h100, 32'd16, 1'b1, 1'b0, 1'b1);
        tick();
        chk_idle("t1.end");

        // Row crossing with 9 column bits.
        cfg_colbits = 2'b01;
        send("t2", 32'h1F8, 9'd20, 1'b1, 1'b0);
        chk_chunk("t2.c0", 32'h1F8, 32'd8, 1'b0, 1'b0, 1'b1);
        tick();
        chk_chunk("t2.c1", 32'h200, 32'd12, 1'b1, 1'b0, 1'b1);
        tick();
        chk_idle("t2.end");

        // Three rows, write, DMA-last only on the final chunk.
        cfg_colbits = 2'b00;
        send("t3", 32'h0F0, 9'd300, 1'b0, 1'b1);
        chk_chunk("t3.c0", 32'h0F0, 32'd16, 1'b0, 1'b0, 1'b0);
        tick();
        chk_chunk("t3.c1", 32'h100, 32'd256, 1'b0, 1'b0, 1'b0);
        tick();
        chk_chunk("t3.c2", 32'h200, 32'd28, 1'b1, 1'b1, 1'b0);
        tick();
        chk_idle("t3.end");

        // Row crossing with 5 stalled cycles per chunk.
        cfg_colbits = 2'b01;
        sub_ack = 1'b0;
        send("t4", 32'h1F8, 9'd20, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_chunk("t4.s0", 32'h1F8, 32'd8, 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk_chunk("t4.c0", 32'h1F8, 32'd8, 1'b0, 1'b0, 1'b1);
        words += int'(sub_len);
        sub_ack = 1'b1;
        tick();
        sub_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_chunk("t4.s1", 32'h200, 32'd12, 1'b1, 1'b0, 1'b1);
            tick();
        end
        chk_chunk("t4.c1", 32'h200, 32'd12, 1'b1, 1'b0, 1'b1);
        words += int'(sub_len);
        sub_ack = 1'b1;
        tick();
        chk_idle("t4.end");
        chk("t4.words", words, 32'd20);

        // Zero-length request: ack only, no sub-request.
        send("t5z", 32'h123, 9'd0, 1'b1, 1'b0);
        chk("t5z.req", {31'd0, sub_req}, 32'd0);
        tick();
        chk_idle("t5z.end");

        // Back to back: second request held while the first is split.
        send("t5a", 32'h1F8, 9'd20, 1'b1, 1'b0);
        req_addr  = 31'h400;
        req_len   = 9'd5;
        req_wr_n  = 1'b0;
        req_valid = 1'b1;
        chk_chunk("t5a.c0", 32'h1F8, 32'd8, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t5a.noack", {31'd0, req_ack}, 32'd0);
        chk_chunk("t5a.c1", 32'h200, 32'd12, 1'b1, 1'b0, 1'b1);
        tick();
        chk_idle("t5.bubble");
        tick();
        chk("t5b.ack", {31'd0, req_ack}, 32'd1);
        req_valid = 1'b0;
        chk_chunk("t5b.c0", 32'h400, 32'd5, 1'b1, 1'b0, 1'b0);
        tick();
        chk_idle("t5b.end");

        // Reset while the second chunk of the three-row case is presented.
        cfg_colbits = 2'b00;
        send("t6", 32'h0F0, 9'd300, 1'b0, 1'b1);
        chk_chunk("t6.c0", 32'h0F0, 32'd16, 1'b0, 1'b0, 1'b0);
        tick();
        chk_chunk("t6.c1", 32'h100, 32'd256, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("t6.rst");
        chk("t6.rst.addr", {1'b0, sub_addr}, 32'd0);
        chk("t6.rst.len",  {23'd0, sub_len}, 32'd0);
        chk("t6.rst.dma",  {31'd0, sub_dma_last}, 32'd0);
        tick();
        chk_idle("t6.quiet");
        send("t7", 32'h3FC, 9'd10, 1'b0, 1'b1);
        chk_chunk("t7.c0", 32'h3FC, 32'd4, 1'b0, 1'b0, 1'b0);
        tick();
        chk_chunk("t7.c1", 32'h400, 32'd6, 1'b1, 1'b1, 1'b0);
        tick();
        chk_idle("t7.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
